// File: rtl/gray_counter_if.sv
// Bus between a gray_counter and whatever drives it: count controls and load
// inputs go in, the registered binary/Gray count and terminal-count pulse come out.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic             load_gray;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             tc;

  // Control inputs have no valid/ready: every input is sampled on each rising
  // clk edge, and the outputs are registered copies of the state after that edge.
  modport master (
    output en, up, load, load_gray, ld_val,
    input  bin_q, gray_q, tc
  );

  modport slave (
    input  en, up, load, load_gray, ld_val,
    output bin_q, gray_q, tc
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray copy, binary or Gray parallel
// load, and optional saturation; intended for async-crossing pointers.
module gray_counter #(
  parameter int          WIDTH = 4,
  parameter bit          WRAP  = 1'b1,
  parameter logic [31:0] INIT  = 32'd0
) (
  input logic           clk,
  input logic           rst,
  gray_counter_if.slave io
);
  localparam logic [WIDTH-1:0] INIT_B = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX    = '1;
  localparam logic [WIDTH-1:0] MIN    = '0;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] gry_q, gry_d;
  logic             tc_q,  tc_d;
  logic [WIDTH-1:0] ld_dec;

  // Gray-to-binary: each binary bit is the running XOR from the MSB down.
  always_comb begin
    ld_dec = '0;
    ld_dec[WIDTH-1] = io.ld_val[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      ld_dec[i] = ld_dec[i+1] ^ io.ld_val[i];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (io.load) begin
      cnt_d = io.load_gray ? ld_dec : io.ld_val;
    end else if (io.en) begin
      if (io.up) begin
        if (cnt_q == MAX) begin
          tc_d = 1'b1;
          if (WRAP) cnt_d = MIN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q == MIN) begin
          tc_d = 1'b1;
          if (WRAP) cnt_d = MAX;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
    // Encoding the next state keeps gray_q a plain flop output, free of decode glitches.
    gry_d = cnt_d ^ (cnt_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= INIT_B;
      gry_q <= INIT_B ^ (INIT_B >> 1);
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      gry_q <= gry_d;
      tc_q  <= tc_d;
    end
  end

  assign io.bin_q  = cnt_q;
  assign io.gray_q = gry_q;
  assign io.tc     = tc_q;
endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: three instances (wrap/INIT=0, saturate/INIT=0,
// wrap/INIT=5) share one stimulus stream and are checked against a counting model.
module tb_gray_counter;
  logic       clk;
  logic       rst;
  logic       en, up, load, load_gray;
  logic [3:0] ld_val;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  gray_counter_if #(.WIDTH(4)) if0 ();
  gray_counter_if #(.WIDTH(4)) if1 ();
  gray_counter_if #(.WIDTH(4)) if2 ();

  assign if0.en = en;  assign if0.up = up;  assign if0.load = load;
  assign if0.load_gray = load_gray;  assign if0.ld_val = ld_val;
  assign if1.en = en;  assign if1.up = up;  assign if1.load = load;
  assign if1.load_gray = load_gray;  assign if1.ld_val = ld_val;
  assign if2.en = en;  assign if2.up = up;  assign if2.load = load;
  assign if2.load_gray = load_gray;  assign if2.ld_val = ld_val;

  gray_counter #(.WIDTH(4), .WRAP(1'b1), .INIT(32'd0)) u_wrap (.clk(clk), .rst(rst), .io(if0));
  gray_counter #(.WIDTH(4), .WRAP(1'b0), .INIT(32'd0)) u_sat  (.clk(clk), .rst(rst), .io(if1));
  gray_counter #(.WIDTH(4), .WRAP(1'b1), .INIT(32'd5)) u_init (.clk(clk), .rst(rst), .io(if2));

  logic [3:0] d_bin[3];
  logic [3:0] d_gray[3];
  logic       d_tc[3];
  assign d_bin[0] = if0.bin_q;  assign d_gray[0] = if0.gray_q;  assign d_tc[0] = if0.tc;
  assign d_bin[1] = if1.bin_q;  assign d_gray[1] = if1.gray_q;  assign d_tc[1] = if1.tc;
  assign d_bin[2] = if2.bin_q;  assign d_gray[2] = if2.gray_q;  assign d_tc[2] = if2.tc;

  // ---------------- reference model ----------------
  bit m_wrap[3] = '{1'b1, 1'b0, 1'b1};
  int m_init[3] = '{0, 0, 5};
  int m_bin[3];
  int m_prev_bin[3];
  bit m_tc[3];
  bit m_count_step;
  bit model_valid = 1'b0;

  function automatic int gray_to_bin(input int g);
    int b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return b & 15;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m_prev_bin[i] = m_bin[i];
      if (rst) begin
        m_bin[i] = m_init[i];
        m_tc[i]  = 1'b0;
      end else if (load) begin
        m_bin[i] = load_gray ? gray_to_bin(int'(ld_val)) : int'(ld_val);
        m_tc[i]  = 1'b0;
      end else if (en) begin
        m_tc[i] = 1'b0;
        if (up) begin
          if (m_bin[i] == 15) begin
            m_tc[i] = 1'b1;
            if (m_wrap[i]) m_bin[i] = 0;
          end else m_bin[i] = m_bin[i] + 1;
        end else begin
          if (m_bin[i] == 0) begin
            m_tc[i] = 1'b1;
            if (m_wrap[i]) m_bin[i] = 15;
          end else m_bin[i] = m_bin[i] - 1;
        end
      end else begin
        m_tc[i] = 1'b0;
      end
    end
    m_count_step = !rst && !load && model_valid;
    if (rst) model_valid = 1'b1;
  end

  // ---------------- scoreboard / compare process ----------------
  logic [3:0] prev_gray[3];
  bit         have_prev = 1'b0;

  always @(negedge clk) begin
    if (model_valid) begin
      for (int i = 0; i < 3; i++) begin
        int exp_gray;
        int flips;
        exp_gray = m_bin[i] ^ (m_bin[i] >> 1);
        checks++;
        if (int'(d_bin[i]) != m_bin[i]) begin
          errors++;
          $display("FAIL model_bin[%0d] t=%0t got %0d exp %0d", i, $time, d_bin[i], m_bin[i]);
        end
        checks++;
        if (int'(d_gray[i]) != exp_gray) begin
          errors++;
          $display("FAIL model_gray[%0d] t=%0t got %h exp %h", i, $time, d_gray[i], exp_gray);
        end
        checks++;
        if (d_tc[i] != m_tc[i]) begin
          errors++;
          $display("FAIL model_tc[%0d] t=%0t got %0b exp %0b", i, $time, d_tc[i], m_tc[i]);
        end
        if (have_prev && m_count_step) begin
          flips = $countones(prev_gray[i] ^ d_gray[i]);
          checks++;
          if (flips != ((m_bin[i] != m_prev_bin[i]) ? 1 : 0)) begin
            errors++;
            $display("FAIL gray_hamming[%0d] t=%0t got %0d bits changed exp %0d", i, $time, flips,
                     (m_bin[i] != m_prev_bin[i]) ? 1 : 0);
          end
        end
        prev_gray[i] = d_gray[i];
      end
      have_prev = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit r, input bit l, input bit lg, input bit e, input bit u,
                      input logic [3:0] v);
    rst = r; load = l; load_gray = lg; en = e; up = u; ld_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [3:0] gtbl[16];
  int exp_b;

  initial begin
    gtbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    rst = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = 1'b0; ld_val = '0;

    step(1, 0, 0, 0, 0, 4'h0);
    chk("reset_bin0", d_bin[0], 0);
    chk("reset_gray0", d_gray[0], 0);
    chk("reset_tc0", d_tc[0], 0);
    chk("reset_bin_init5", d_bin[2], 5);
    chk("reset_gray_init5", d_gray[2], 7);
    chk("reset_tc_init5", d_tc[2], 0);

    // Full up-count lap on the wrapping instance.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1, 4'h0);
      exp_b = (i + 1) % 16;
      chk("lap_bin", d_bin[0], exp_b);
      chk("lap_gray", d_gray[0], gtbl[exp_b]);
      chk("lap_tc", d_tc[0], (i == 15) ? 1 : 0);
    end
    chk("sat_hold_bin", d_bin[1], 15);
    chk("sat_hold_tc", d_tc[1], 1);

    // Down-wrap from 0.
    step(0, 0, 0, 1, 0, 4'h0);
    chk("dnwrap_bin", d_bin[0], 15);
    chk("dnwrap_gray", d_gray[0], 8);
    chk("dnwrap_tc", d_tc[0], 1);
    step(0, 0, 0, 1, 0, 4'h0);
    chk("dn_bin", d_bin[0], 14);
    chk("dn_tc", d_tc[0], 0);

    // Gray load wins over en.
    step(0, 1, 1, 1, 1, 4'b1101);
    chk("gload_bin", d_bin[0], 9);
    chk("gload_gray", d_gray[0], 13);
    chk("gload_tc", d_tc[0], 0);
    chk("gload_bin_sat", d_bin[1], 9);

    // Saturating instance: load 14 and push up into the limit.
    step(0, 1, 0, 1, 1, 4'd14);
    chk("bload_bin", d_bin[1], 14);
    chk("bload_tc", d_tc[1], 0);
    step(0, 0, 0, 1, 1, 4'h0);
    chk("sat1_bin", d_bin[1], 15);  chk("sat1_tc", d_tc[1], 0);
    step(0, 0, 0, 1, 1, 4'h0);
    chk("sat2_bin", d_bin[1], 15);  chk("sat2_tc", d_tc[1], 1);
    step(0, 0, 0, 1, 1, 4'h0);
    chk("sat3_bin", d_bin[1], 15);  chk("sat3_tc", d_tc[1], 1);
    step(0, 0, 0, 1, 0, 4'h0);
    chk("sat_dn_bin", d_bin[1], 14);  chk("sat_dn_tc", d_tc[1], 0);

    // Saturate at zero.
    step(1, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 0, 4'h0);
    chk("sat0_bin", d_bin[1], 0);  chk("sat0_tc", d_tc[1], 1);

    // INIT=5: count to 11, then reset collides with load and en.
    step(1, 0, 0, 0, 0, 4'h0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 4'h0);
    chk("init_cnt_bin", d_bin[2], 11);
    step(1, 1, 0, 1, 1, 4'h3);
    chk("rst_pri_bin", d_bin[2], 5);
    chk("rst_pri_gray", d_gray[2], 7);
    chk("rst_pri_tc", d_tc[2], 0);
    chk("rst_pri_bin0", d_bin[0], 0);

    // Random traffic, checked by the model on every cycle.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    step(0, 0, 0, 0, 0, 4'h0);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
